// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: recovers hex digits from a multiplexed active-low seven-segment scan bus.
// Optional macro SEVENSEG_SCAN_DECODER_ERRCNT_EN enables a saturating illegal-glyph counter on err_count.
module sevenseg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  anodes,
  input  logic [6:0]  segments,
  output logic [31:0] hex_out,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic [7:0]  err_count
);
  logic [7:0]  prev_anodes;
  logic [6:0]  prev_segments;
  logic [7:0]  cnt;
  logic        done;
  logic [31:0] shadow;
  logic [7:0]  mask;
  logic [7:0]  mask_next;
  logic        dwell_ok;
  logic        same;
  logic        sample;
  logic        legal;
  logic [3:0]  nib;
  logic [2:0]  digit;
  assign dwell_ok = $onehot(~anodes);
  assign same     = (anodes == prev_anodes) && (segments == prev_segments);
  assign sample   = (cnt == 8'(STABLE_CYCLES)) && !done;
  // Selected digit index of the dwell held in the previous-cycle registers.
  always_comb begin
    digit = 3'd0;
    for (int i = 0; i < 8; i++)
      if (!prev_anodes[i]) digit = 3'(i);
  end
  // Map an active-low glyph to its nibble; anything outside the 16 glyphs is illegal.
  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (prev_segments)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // A completed mask is retired this edge, so a coincident capture starts the next frame.
  always_comb begin
    mask_next = &mask ? 8'h00 : mask;
    mask_next = !sample ? mask_next : legal ? (mask_next | (8'h01 << digit)) : 8'h00;
  end
  // Dwell stability counter; done blocks a second sample within the same dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_anodes   <= 8'hFF;
      prev_segments <= 7'h7F;
      cnt           <= 8'd0;
      done          <= 1'b0;
    end else begin
      prev_anodes   <= anodes;
      prev_segments <= segments;
      cnt           <= !dwell_ok ? 8'd0 : !same ? 8'd1 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      done          <= dwell_ok && same && (done || sample);
    end
  end
  // Shadow capture, frame publication and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow      <= 32'h0;
      mask        <= 8'h00;
      hex_out     <= 32'h0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      frame_valid <= &mask;
      pattern_err <= sample && !legal;
      mask        <= mask_next;
      if (&mask) hex_out <= shadow;
      if (sample && legal) shadow[{digit, 2'b00} +: 4] <= nib;
    end
  end
`ifdef SEVENSEG_SCAN_DECODER_ERRCNT_EN
  // Saturating count of illegal-glyph pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= 8'h00;
    else if (pattern_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder: directed scan sequences checked against a dwell/frame reference model.
module tb_sevenseg_scan_decoder;
  localparam int STABLE = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  anodes = 8'hFF;
  logic [6:0]  segments = 7'h7F;
  logic [31:0] hex_out;
  logic        frame_valid;
  logic        pattern_err;
  logic [7:0]  err_count;
  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int pe_cnt = 0;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  sevenseg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .anodes(anodes), .segments(segments),
    .hex_out(hex_out), .frame_valid(frame_valid), .pattern_err(pattern_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  // Reference model: run length of identical single-digit dwells, per-digit nibble/capture arrays,
  // with the sample landing one edge after the dwell reaches STABLE and the frame one edge later.
  int         run = 0;
  logic [7:0] la = 8'hFF;
  logic [6:0] ls = 7'h7F;
  bit         smp_pend = 0;
  int         smp_digit = 0;
  logic [6:0] smp_seg = 7'h7F;
  bit         fr_pend = 0;
  int         m_nib [8] = '{default: 0};
  bit         m_cap [8] = '{default: 0};
  logic [31:0] m_hex = 32'h0;
  bit         m_fv = 0;
  bit         m_pe = 0;
  int         m_ec = 0;
  always @(posedge clk) begin
    if (reset) begin
      run = 0; la = 8'hFF; ls = 7'h7F; smp_pend = 0; fr_pend = 0;
      m_nib = '{default: 0}; m_cap = '{default: 0};
      m_hex = 32'h0; m_fv = 0; m_pe = 0; m_ec = 0;
    end else begin
`ifdef SEVENSEG_SCAN_DECODER_ERRCNT_EN
      if (m_pe && m_ec < 255) m_ec++;
`endif
      m_fv = 0;
      m_pe = 0;
      if (fr_pend) begin
        m_hex = 32'h0;
        for (int i = 0; i < 8; i++) m_hex = m_hex + (32'(m_nib[i]) << (4 * i));
        m_fv = 1;
        fr_pend = 0;
        m_cap = '{default: 0};
      end
      if (smp_pend) begin
        int v;
        bit all;
        v = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == smp_seg) v = g;
        if (v >= 0) begin
          m_nib[smp_digit] = v;
          m_cap[smp_digit] = 1;
          all = 1;
          for (int i = 0; i < 8; i++) all = all & m_cap[i];
          fr_pend = all;
        end else begin
          m_pe = 1;
          m_cap = '{default: 0};
        end
        smp_pend = 0;
      end
      if ($countones(~anodes) != 1) run = 0;
      else if (anodes == la && segments == ls) run++;
      else run = 1;
      la = anodes;
      ls = segments;
      if (run == STABLE) begin
        smp_pend = 1;
        smp_seg = segments;
        for (int i = 0; i < 8; i++) if (!anodes[i]) smp_digit = i;
      end
    end
  end
  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_hex", hex_out, 32'h0);
      check("rst_fv", 32'(frame_valid), 32'h0);
      check("rst_pe", 32'(pattern_err), 32'h0);
      check("rst_ec", 32'(err_count), 32'h0);
    end else begin
      check("hex_out", hex_out, m_hex);
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("pattern_err", 32'(pattern_err), 32'(m_pe));
      check("err_count", 32'(err_count), 32'(m_ec));
      if (frame_valid) fv_cnt++;
      if (pattern_err) pe_cnt++;
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic dwell(input int d, input logic [6:0] seg, input int n);
    anodes = 8'(~(8'h01 << d));
    segments = seg;
    step(n);
  endtask
  task automatic idle(input int n);
    anodes = 8'hFF;
    segments = 7'h7F;
    step(n);
  endtask
  initial begin
    int f0, p0;
    step(3);
    check("lit_reset_hex", hex_out, 32'h0);
    check("lit_reset_fv", 32'(frame_valid), 32'h0);
    reset = 1'b0;
    idle(2);
    f0 = fv_cnt;
    for (int d = 0; d < 8; d++) dwell(d, glyph[d + 1], 3);
    idle(6);
    check("lit_short_fv", 32'(fv_cnt - f0), 32'd0);
    check("lit_short_hex", hex_out, 32'h0);
    f0 = fv_cnt;
    for (int d = 0; d < 8; d++) dwell(d, glyph[d + 1], 10);
    idle(4);
    check("lit_frame_fv", 32'(fv_cnt - f0), 32'd1);
    check("lit_frame_hex", hex_out, 32'h87654321);
    f0 = fv_cnt;
    for (int d = 0; d < 8; d++) dwell(d, glyph[15 - d], STABLE);
    idle(4);
    check("lit_edge_fv", 32'(fv_cnt - f0), 32'd1);
    check("lit_edge_hex", hex_out, 32'h89ABCDEF);
    p0 = pe_cnt;
    for (int d = 0; d < 3; d++) dwell(d, glyph[5], 6);
    dwell(3, 7'h7F, 6);
    idle(3);
    check("lit_blank_pe", 32'(pe_cnt - p0), 32'd1);
    check("lit_blank_hex", hex_out, 32'h89ABCDEF);
`ifdef SEVENSEG_SCAN_DECODER_ERRCNT_EN
    check("lit_blank_ec", 32'(err_count), 32'd1);
`else
    check("lit_blank_ec", 32'(err_count), 32'd0);
`endif
    f0 = fv_cnt;
    for (int d = 0; d < 8; d++) dwell(d, glyph[10], 6);
    idle(4);
    check("lit_a_fv", 32'(fv_cnt - f0), 32'd1);
    check("lit_a_hex", hex_out, 32'hAAAAAAAA);
    f0 = fv_cnt;
    p0 = pe_cnt;
    for (int d = 0; d < 4; d++) dwell(d, glyph[9], 6);
    anodes = 8'b11110011;
    segments = glyph[9];
    step(20);
    for (int d = 4; d < 8; d++) dwell(d, glyph[9], 6);
    idle(4);
    check("lit_multi_fv", 32'(fv_cnt - f0), 32'd1);
    check("lit_multi_pe", 32'(pe_cnt - p0), 32'd0);
    check("lit_multi_hex", hex_out, 32'h99999999);
    dwell(2, 7'h19, 6);
    dwell(2, 7'h0E, 6);
    for (int d = 0; d < 8; d++) if (d != 2) dwell(d, 7'h40, 6);
    idle(4);
    check("lit_over_hex", hex_out, 32'h00000F00);
    f0 = fv_cnt;
    for (int d = 0; d < 6; d++) dwell(d, glyph[1], 6);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int d = 6; d < 8; d++) dwell(d, glyph[1], 6);
    idle(6);
    check("lit_rst_fv", 32'(fv_cnt - f0), 32'd0);
    check("lit_rst_hex", hex_out, 32'h0);
    check("lit_rst_ec", 32'(err_count), 32'd0);
    check("lit_rst_pe", 32'(pattern_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_decoder.md
SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive identical cycles of anodes and segments required before a digit is sampled (legal range 1..255).
REQ-003 Port clk, input, width 1, SHALL be the system clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, width 1, SHALL be the asynchronous active-high reset.
REQ-005 Port anodes, input, width 8, SHALL carry active-low digit enables; anodes[i]=0 selects digit i.
REQ-006 Port segments, input, width 7, SHALL carry active-low segment levels, with segments[0]=a through segments[6]=g.
REQ-007 Port hex_out, output, width 32, SHALL hold the last complete frame; digit i occupies hex_out[4i+3:4i].
REQ-008 Port frame_valid, output, width 1, SHALL pulse high for one cycle when hex_out is updated.
REQ-009 Port pattern_err, output, width 1, SHALL pulse high for one cycle when a sampled segment pattern is not a legal hex glyph.
REQ-010 Port err_count, output, width 8, SHALL report the illegal-pattern count (see Configuration).

Function
REQ-011 The block SHALL recognise a dwell only when exactly one anodes bit is 0; an all-ones or multi-zero anodes value SHALL clear the stability counter and SHALL NOT be sampled.
REQ-012 The stability counter SHALL increment while anodes and segments equal their values from the previous cycle and the dwell is valid, SHALL saturate, and SHALL reload to 1 on any change.
REQ-013 On the cycle the counter first equals STABLE_CYCLES, the block SHALL decode segments exactly once per dwell; it SHALL NOT resample until anodes or segments change.
REQ-014 The legal glyphs (segments in hex, active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E; any other pattern is illegal.
REQ-015 A legal sample SHALL write its nibble into an internal shadow register at digit i and set capture-mask bit i; a repeat capture of digit i before frame completion SHALL overwrite the nibble.
REQ-016 An illegal sample SHALL assert pattern_err for one cycle, SHALL NOT change the shadow register, and SHALL clear the entire capture mask.
REQ-017 When the capture mask becomes 8'hFF, on the next rising edge the block SHALL copy the shadow register to hex_out, assert frame_valid for one cycle, and clear the mask.
REQ-018 A capture that completes one frame while a new dwell begins SHALL NOT lose the new dwell; the stability counter SHALL run independently of the frame logic.
REQ-019 hex_out SHALL change only together with frame_valid.

Reset
REQ-020 While reset is high: hex_out=32'h0, frame_valid=0, pattern_err=0, err_count=0, shadow register=0, capture mask=0, stability counter=0.
REQ-021 Reset asserted mid-frame SHALL discard all partial captures; after reset is released, a full new set of 8 digits SHALL be required before frame_valid asserts.

Configuration
REQ-022 When macro SEVENSEG_SCAN_DECODER_ERRCNT_EN is defined, err_count SHALL increment by 1 on each pattern_err pulse, saturating at 8'hFF.
REQ-023 When SEVENSEG_SCAN_DECODER_ERRCNT_EN is not defined, err_count SHALL be constant 8'h00 and no counter logic SHALL be synthesised.

Verification
REQ-024 Drive digits 0..7 in sequence with glyphs for 1,2,3,4,5,6,7,8, each for 10 cycles, STABLE_CYCLES=4 -> one frame_valid pulse, hex_out=32'h87654321.
REQ-025 Hold each dwell for only 3 cycles with STABLE_CYCLES=4 -> no frame_valid, hex_out stays 32'h0.
REQ-026 Send a partial frame, then drive segments=7'h7F (blank) on digit 3 -> pattern_err pulses once, mask clears, err_count=1 with the macro and 0 without it; a later full frame of all 0xA glyphs -> hex_out=32'hAAAAAAAA.
REQ-027 Drive anodes=8'b11110011 for 20 cycles mid-frame -> no sample, no pattern_err; frame completes normally afterwards.
REQ-028 Capture digits 0..5, then assert reset for 2 cycles, then capture only digits 6..7 -> no frame_valid, all outputs 0.
REQ-029 Capture digit 2 as 7'h19, then again as 7'h0E before completing the frame with 0 glyphs -> hex_out=32'h00000F00.
